core_inst_seq: RTL

On-chip instruction sequencer that drives the 34-bit `inst` bus of `core` and replaces the hand-stepped phase sequence of the bench. After a `start` pulse it runs, for each kernel position kij, the weight fetch to IFIFO, weight load, settle gap, activation fetch to L0, execute, and OFIFO-to-psum writeback. It then runs the output-stationary accumulation pass that reads psum memory through the SFU. It sits directly upstream of `core` and owns every `inst` field; activations and weights are preloaded into xmem by the host.

---
 rtl/core_inst_seq.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/core_inst_seq.sv
// Instruction sequencer for `core`: per-kij weight/activation/execute/writeback
// phases, then an output-stationary accumulation pass through the SFU.
module core_inst_seq #(
   parameter int          COL   = 8,
   parameter int          ROW   = 8,
   parameter int          IN_W  = 6,
   parameter int          K     = 3,
   parameter logic [10:0] WBASE = 11'h400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ofifo_valid,
   output logic [33:0] inst,
   output logic        acc_clr,
   output logic        sfp_valid,
   output logic        busy,
   output logic        done
);

   localparam int LEN_NIJ = IN_W * IN_W;
   localparam int LEN_KIJ = K * K;
   localparam int OUT_W   = IN_W - K + 1;
   localparam int T_W     = $clog2(LEN_NIJ + 2 * ROW + 2 * COL + 16);
   localparam int KIJ_W   = $clog2(LEN_KIJ + 1);
   localparam int O_W     = $clog2(OUT_W + 1);
   localparam int KK_W    = $clog2(K + 1);

   localparam logic [T_W-1:0]   T_W_L0_LAST   = T_W'(COL);
   localparam logic [T_W-1:0]   T_W_LOAD_LAST = T_W'(ROW + 2 * COL - 1);
   localparam logic [T_W-1:0]   T_GAP_LAST    = T_W'(10);
   localparam logic [T_W-1:0]   T_A_L0_LAST   = T_W'(LEN_NIJ - 1);
   localparam logic [T_W-1:0]   T_EXEC_LAST   = T_W'(LEN_NIJ + ROW + COL - 1);
   localparam logic [T_W-1:0]   T_OFIFO_LAST  = T_W'(LEN_NIJ);
   localparam logic [T_W-1:0]   T_ACC_RD_LAST = T_W'(LEN_KIJ);
   localparam logic [KIJ_W-1:0] KIJ_LAST      = KIJ_W'(LEN_KIJ - 1);
   localparam logic [O_W-1:0]   O_LAST        = O_W'(OUT_W - 1);
   localparam logic [KK_W-1:0]  KJ_LAST       = KK_W'(K - 1);

   typedef struct packed {
      logic        acc;
      logic        cen_pmem;
      logic        wen_pmem;
      logic [10:0] a_pmem;
      logic        cen_xmem;
      logic        wen_xmem;
      logic [10:0] a_xmem;
      logic        ofifo_rd;
      logic        ififo_wr;
      logic        ififo_rd;
      logic        l0_rd;
      logic        l0_wr;
      logic        execute;
      logic        load;
   } inst_t;

   localparam inst_t IDLE_WORD = inst_t'(34'h1800C0000);

   typedef enum logic [3:0] {
      S_IDLE, S_W_L0, S_W_LOAD, S_GAP, S_A_L0, S_EXEC,
      S_DRAIN, S_OFIFO, S_ACC_CLR, S_ACC_RD, S_ACC_OUT
   } state_t;

   state_t            state, state_n;
   logic [T_W-1:0]    t, t_n;
   logic [KIJ_W-1:0]  kij, kij_n;
   logic [O_W-1:0]    oy, oy_n, ox, ox_n;
   logic [KK_W-1:0]   ki, ki_n, kj, kj_n;
   inst_t             word_n;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_n = state;
      t_n     = t + 1'b1;
      kij_n   = kij;
      oy_n    = oy;
      ox_n    = ox;
      ki_n    = ki;
      kj_n    = kj;
      unique case (state)
         S_IDLE: begin
            t_n = '0;
            if (start) begin
               state_n = S_W_L0;
               kij_n   = '0;
            end
         end
         S_W_L0:   if (t == T_W_L0_LAST)   begin state_n = S_W_LOAD; t_n = '0; end
         S_W_LOAD: if (t == T_W_LOAD_LAST) begin state_n = S_GAP;    t_n = '0; end
         S_GAP:    if (t == T_GAP_LAST)    begin state_n = S_A_L0;   t_n = '0; end
         S_A_L0:   if (t == T_A_L0_LAST)   begin state_n = S_EXEC;   t_n = '0; end
         S_EXEC:   if (t == T_EXEC_LAST)   begin state_n = S_DRAIN;  t_n = '0; end
         S_DRAIN: begin
            t_n = '0;
            if (ofifo_valid) state_n = S_OFIFO;
         end
         S_OFIFO: begin
            if (t == T_OFIFO_LAST) begin
               t_n = '0;
               if (kij == KIJ_LAST) begin
                  state_n = S_ACC_CLR;
                  oy_n    = '0;
                  ox_n    = '0;
               end else begin
                  state_n = S_W_L0;
                  kij_n   = kij + 1'b1;
               end
            end
         end
         S_ACC_CLR: begin
            state_n = S_ACC_RD;
            t_n     = '0;
            ki_n    = '0;
            kj_n    = '0;
         end
         S_ACC_RD: begin
            // ki/kj track j/K and j%K as wrap counters
            if (t == T_ACC_RD_LAST) begin
               state_n = S_ACC_OUT;
               t_n     = '0;
            end else if (kj == KJ_LAST) begin
               kj_n = '0;
               ki_n = ki + 1'b1;
            end else begin
               kj_n = kj + 1'b1;
            end
         end
         S_ACC_OUT: begin
            t_n     = '0;
            state_n = S_ACC_CLR;
            if (ox == O_LAST) begin
               ox_n = '0;
               if (oy == O_LAST) state_n = S_IDLE;
               else              oy_n    = oy + 1'b1;
            end else begin
               ox_n = ox + 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Outputs are decoded from the state being entered so the registered word lines up with it.
   always_comb begin
      word_n = IDLE_WORD;
      unique case (state_n)
         S_W_L0: begin
            word_n.ififo_wr = 1'b1;
            word_n.cen_xmem = 1'b0;
            word_n.a_xmem   = 11'(int'(WBASE) + int'(kij_n) * COL + int'(t_n));
         end
         S_W_LOAD: begin
            word_n.ififo_rd = 1'b1;
            word_n.load     = 1'b1;
         end
         S_A_L0: begin
            word_n.l0_wr    = 1'b1;
            word_n.cen_xmem = 1'b0;
            word_n.a_xmem   = 11'(t_n);
         end
         S_EXEC: begin
            word_n.l0_rd   = 1'b1;
            word_n.execute = 1'b1;
         end
         S_OFIFO: begin
            word_n.ofifo_rd = 1'b1;
            word_n.cen_pmem = 1'b0;
            word_n.wen_pmem = 1'b0;
            word_n.a_pmem   = 11'(int'(kij_n) * LEN_NIJ + int'(t_n));
         end
         S_ACC_RD: begin
            word_n.acc = (t_n != '0);
            if (t_n != T_ACC_RD_LAST) begin
               word_n.cen_pmem = 1'b0;
               word_n.a_pmem   = 11'(int'(t_n) * LEN_NIJ + (int'(oy_n) + int'(ki_n)) * IN_W
                                     + int'(ox_n) + int'(kj_n));
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         t         <= '0;
         kij       <= '0;
         oy        <= '0;
         ox        <= '0;
         ki        <= '0;
         kj        <= '0;
         inst      <= IDLE_WORD;
         acc_clr   <= 1'b0;
         sfp_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         t         <= t_n;
         kij       <= kij_n;
         oy        <= oy_n;
         ox        <= ox_n;
         ki        <= ki_n;
         kj        <= kj_n;
         inst      <= word_n;
         acc_clr   <= (state_n == S_ACC_CLR);
         sfp_valid <= (state_n == S_ACC_OUT);
         busy      <= (state_n != S_IDLE);
         done      <= (state == S_ACC_OUT) && (state_n == S_IDLE);
      end
   end

endmodule
